// File: rtl/framer.sv
// framer: packs PackedNum narrow elements (element 0 in the LSBs) into one word and frames every
// PacketLenElems payload words with two header words. Define FRAMER_CHECKSUM_EN to append an XOR checksum word.
module framer #(
    parameter int unsigned                        UnpackedWidth  = 1,
    parameter int unsigned                        PackedNum      = 8,
    parameter int unsigned                        PacketLenElems = 1024,
    parameter logic [UnpackedWidth*PackedNum-1:0] HeaderByte0    = (UnpackedWidth*PackedNum)'(8'hA5),
    parameter logic [UnpackedWidth*PackedNum-1:0] HeaderByte1    = (UnpackedWidth*PackedNum)'(8'h5A)
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  logic                               valid_i,
    output logic                               ready_o,
    input  logic [UnpackedWidth-1:0]           unpacked_i,
    output logic                               valid_o,
    input  logic                               ready_i,
    output logic [UnpackedWidth*PackedNum-1:0] data_o
);
    localparam int unsigned PackedWidth = UnpackedWidth * PackedNum;
    localparam int unsigned ElemW       = (PackedNum > 1) ? $clog2(PackedNum) : 1;
    localparam int unsigned CntW        = $clog2(PacketLenElems + 1);
    localparam logic [ElemW-1:0] ElemLast = ElemW'(PackedNum - 1);
    localparam logic [CntW-1:0]  CntLast  = CntW'(PacketLenElems);

    typedef enum logic [2:0] {
        Idle,
        Hdr0,
        Hdr1,
        Payload,
        Tail
`ifdef FRAMER_CHECKSUM_EN
        , Csum
`endif
    } state_e;

    state_e                 state_q, state_d;
    logic                   valid_q, valid_d;
    logic [PackedWidth-1:0] data_q, data_d;
    logic [PackedWidth-1:0] pack_q, pack_d;
    logic [ElemW-1:0]       elem_q, elem_d;
    logic [CntW-1:0]        cnt_q, cnt_d;
`ifdef FRAMER_CHECKSUM_EN
    logic [PackedWidth-1:0] csum_q, csum_d;
`endif

    logic                   in_ready;
    logic                   out_fire;
    logic [CntW-1:0]        cnt_inc;
    logic [PackedWidth-1:0] pack_ins;

    assign out_fire = valid_q && ready_i;
    assign cnt_inc  = cnt_q + CntW'(1);

    // Pack register with the current element dropped into its slot; used both for
    // partial updates and as the completed word when the last slot is filled.
    for (genvar gi = 0; gi < PackedNum; gi++) begin : g_ins
        assign pack_ins[gi*UnpackedWidth +: UnpackedWidth] =
            (elem_q == ElemW'(gi)) ? unpacked_i : pack_q[gi*UnpackedWidth +: UnpackedWidth];
    end

    always_comb begin
        state_d  = state_q;
        valid_d  = valid_q;
        data_d   = data_q;
        pack_d   = pack_q;
        elem_d   = elem_q;
        cnt_d    = cnt_q;
`ifdef FRAMER_CHECKSUM_EN
        csum_d   = csum_q;
`endif
        in_ready = 1'b0;

        case (state_q)
            Idle: begin
                elem_d = '0;
                cnt_d  = '0;
`ifdef FRAMER_CHECKSUM_EN
                csum_d = '0;
`endif
                // The pending element only triggers the header; it is consumed in Payload.
                if (valid_i) begin
                    data_d  = HeaderByte0;
                    valid_d = 1'b1;
                    state_d = Hdr0;
                end
            end
            Hdr0: begin
                if (out_fire) begin
                    data_d  = HeaderByte1;
                    state_d = Hdr1;
                end
            end
            Hdr1: begin
                if (out_fire) begin
                    valid_d = 1'b0;
                    state_d = Payload;
                end
            end
            Payload: begin
                // Only the word-completing element needs room in the output register.
                in_ready = (elem_q == ElemLast) ? (!valid_q || ready_i) : 1'b1;
                if (out_fire) begin
                    valid_d = 1'b0;
                end
                if (valid_i && in_ready) begin
                    if (elem_q == ElemLast) begin
                        data_d  = pack_ins;
                        valid_d = 1'b1;
                        elem_d  = '0;
                        cnt_d   = cnt_inc;
`ifdef FRAMER_CHECKSUM_EN
                        csum_d  = csum_q ^ pack_ins;
`endif
                        if (cnt_inc == CntLast) begin
                            state_d = Tail;
                        end
                    end else begin
                        pack_d = pack_ins;
                        elem_d = elem_q + ElemW'(1);
                    end
                end
            end
            Tail: begin
                if (out_fire) begin
`ifdef FRAMER_CHECKSUM_EN
                    data_d  = csum_q;
                    state_d = Csum;
`else
                    valid_d = 1'b0;
                    cnt_d   = '0;
                    state_d = Idle;
`endif
                end
            end
`ifdef FRAMER_CHECKSUM_EN
            Csum: begin
                if (out_fire) begin
                    valid_d = 1'b0;
                    cnt_d   = '0;
                    state_d = Idle;
                end
            end
`endif
            default: begin
                state_d = Idle;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= Idle;
            valid_q <= 1'b0;
            data_q  <= '0;
            pack_q  <= '0;
            elem_q  <= '0;
            cnt_q   <= '0;
`ifdef FRAMER_CHECKSUM_EN
            csum_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            pack_q  <= pack_d;
            elem_q  <= elem_d;
            cnt_q   <= cnt_d;
`ifdef FRAMER_CHECKSUM_EN
            csum_q  <= csum_d;
`endif
        end
    end

    assign ready_o = in_ready;
    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: tb/tb_framer.sv
// tb_framer: table-driven packets plus hand-written stall/reset/back-to-back sequences,
// all output words checked against a scoreboard queue filled when stimulus is driven.
module tb_framer;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n = 1'b0;
    // dut0: PacketLenElems=2, dut1: PacketLenElems=1
    logic       valid0_i = 1'b0, ready0_i = 1'b1, ready0_o, valid0_o;
    logic [1:0] unp0_i = 2'd0;
    logic [7:0] data0_o;
    logic       valid1_i = 1'b0, ready1_i = 1'b1, ready1_o, valid1_o;
    logic [1:0] unp1_i = 2'd0;
    logic [7:0] data1_o;

    framer #(.UnpackedWidth(2), .PackedNum(4), .PacketLenElems(2)) dut (
        .clk_i(clk), .rst_ni(rst_n), .valid_i(valid0_i), .ready_o(ready0_o),
        .unpacked_i(unp0_i), .valid_o(valid0_o), .ready_i(ready0_i), .data_o(data0_o)
    );

    framer #(.UnpackedWidth(2), .PackedNum(4), .PacketLenElems(1)) dut1 (
        .clk_i(clk), .rst_ni(rst_n), .valid_i(valid1_i), .ready_o(ready1_o),
        .unpacked_i(unp1_i), .valid_o(valid1_o), .ready_i(ready1_i), .data_o(data1_o)
    );

    typedef struct packed {
        logic [7:0][1:0] elems;  // elems[0] is sent first
        logic [7:0]      w0;
        logic [7:0]      w1;
        logic [7:0]      cs;
    } pkt_t;

    int         n_checks = 0;
    int         n_pass   = 0;
    int         cyc      = 0;
    bit         in_fire0, in_fire1;
    bit         rdy_rand  = 1'b0;
    logic       rdy_force = 1'b1;
    logic [7:0] exp0_q[$];
    logic [7:0] exp1_q[$];
    int         fire_cyc1[$];
    pkt_t       tbl[3];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic push0(input logic [7:0] w);
        exp0_q.push_back(w);
    endtask

    // One clock: sample handshakes and score outputs at negedge, drive ready after posedge.
    task automatic step();
        logic [7:0] e;
        @(negedge clk);
        in_fire0 = valid0_i && ready0_o;
        in_fire1 = valid1_i && ready1_o;
        if (rst_n && valid0_o && ready0_i) begin
            if (exp0_q.size() == 0) begin
                n_checks++;
                $display("FAIL out0_extra: got %02h, nothing expected", data0_o);
            end else begin
                e = exp0_q.pop_front();
                $display("dut0 word %02h (expected %02h) at cycle %0d", data0_o, e, cyc);
                check("out0", 32'(data0_o), 32'(e));
            end
        end
        if (rst_n && valid1_o && ready1_i) begin
            fire_cyc1.push_back(cyc);
            if (exp1_q.size() == 0) begin
                n_checks++;
                $display("FAIL out1_extra: got %02h, nothing expected", data1_o);
            end else begin
                e = exp1_q.pop_front();
                $display("dut1 word %02h (expected %02h) at cycle %0d", data1_o, e, cyc);
                check("out1", 32'(data1_o), 32'(e));
            end
        end
        cyc++;
        @(posedge clk);
        #1;
        ready0_i = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_force;
        #1;
    endtask

    task automatic send(input int which, input logic [1:0] e);
        bit ok = 1'b0;
        if (which == 0) begin valid0_i = 1'b1; unp0_i = e; end
        else begin valid1_i = 1'b1; unp1_i = e; end
        for (int c = 0; c < 64; c++) begin
            step();
            if ((which == 0) ? in_fire0 : in_fire1) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_checks++;
            $display("FAIL send%0d_timeout: element %0d not accepted, required acceptance", which, e);
        end
    endtask

    task automatic drain(input string name);
        for (int c = 0; c < 100 && (exp0_q.size() != 0 || exp1_q.size() != 0); c++) step();
        check({name, "_left0"}, 32'(exp0_q.size()), 32'd0);
        check({name, "_left1"}, 32'(exp1_q.size()), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        tbl[0] = '{elems: {2'd3, 2'd3, 2'd3, 2'd3, 2'd0, 2'd3, 2'd2, 2'd1}, w0: 8'h39, w1: 8'hFF, cs: 8'hC6};
        tbl[1] = '{elems: {2'd2, 2'd2, 2'd2, 2'd2, 2'd3, 2'd2, 2'd1, 2'd0}, w0: 8'hE4, w1: 8'hAA, cs: 8'h4E};
        tbl[2] = '{elems: {2'd2, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd3}, w0: 8'h03, w1: 8'h80, cs: 8'h83};

        // Reset held two cycles with valid_i high
        rst_n = 1'b0; valid0_i = 1'b1; valid1_i = 1'b1;
        step(); step();
        check("rst_valid0", 32'(valid0_o), 32'd0);
        check("rst_ready0", 32'(ready0_o), 32'd0);
        check("rst_data0",  32'(data0_o),  32'd0);
        check("rst_valid1", 32'(valid1_o), 32'd0);
        check("rst_ready1", 32'(ready1_o), 32'd0);
        valid0_i = 1'b0; valid1_i = 1'b0; rst_n = 1'b1;
        for (int i = 0; i < 5; i++) step();
        check("idle_no_hdr0", 32'(valid0_o), 32'd0);
        check("idle_no_hdr1", 32'(valid1_o), 32'd0);

        // Table packets: first with ready_i high, the rest with random backpressure
        for (int p = 0; p < 3; p++) begin
            rdy_rand = (p != 0);
            push0(8'hA5); push0(8'h5A); push0(tbl[p].w0); push0(tbl[p].w1);
`ifdef FRAMER_CHECKSUM_EN
            push0(tbl[p].cs);
`endif
            for (int w = 0; w < 2; w++) begin
                for (int k = 0; k < 4; k++) begin
                    send(0, tbl[p].elems[w*4+k]);
                end
                check($sformatf("lat_p%0d_w%0d", p, w), {23'd0, valid0_o, data0_o},
                      {23'd0, 1'b1, (w == 0) ? tbl[p].w0 : tbl[p].w1});
            end
            valid0_i = 1'b0;
            drain($sformatf("pkt%0d", p));
            step(); step();
            check($sformatf("idle_valid_p%0d", p), 32'(valid0_o), 32'd0);
            check($sformatf("idle_ready_p%0d", p), 32'(ready0_o), 32'd0);
        end
        rdy_rand = 1'b0; rdy_force = 1'b1; step();

        // Output stalled while the first payload word is presented
        push0(8'hA5); push0(8'h5A); push0(8'h39); push0(8'hFF);
`ifdef FRAMER_CHECKSUM_EN
        push0(8'hC6);
`endif
        send(0, 2'd1); send(0, 2'd2); send(0, 2'd3); send(0, 2'd0);
        check("stall_load", {23'd0, valid0_o, data0_o}, {23'd0, 1'b1, 8'h39});
        rdy_force = 1'b0; ready0_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            send(0, 2'd3);
            check($sformatf("stall_hold%0d", i), {23'd0, valid0_o, data0_o}, {23'd0, 1'b1, 8'h39});
        end
        valid0_i = 1'b1; unp0_i = 2'd3;
        step();
        check("stall_ready_low", 32'(in_fire0), 32'd0);
        check("stall_hold3", 32'(data0_o), 32'h39);
        rdy_force = 1'b1; ready0_i = 1'b1;
        send(0, 2'd3);
        check("stall_next", {23'd0, valid0_o, data0_o}, {23'd0, 1'b1, 8'hFF});
        valid0_i = 1'b0;
        drain("stall");

        // Reset in the middle of the first payload word
        push0(8'hA5); push0(8'h5A);
        send(0, 2'd3); send(0, 2'd3);
        valid0_i = 1'b0;
        drain("pre_rst");
        rst_n = 1'b0;
        step();
        check("midrst_valid", 32'(valid0_o), 32'd0);
        rst_n = 1'b1;
        push0(8'hA5); push0(8'h5A); push0(8'h40); push0(8'h55);
`ifdef FRAMER_CHECKSUM_EN
        push0(8'h15);
`endif
        send(0, 2'd0); send(0, 2'd0); send(0, 2'd0); send(0, 2'd1);
        check("midrst_word", 32'(data0_o), 32'h40);
        for (int i = 0; i < 4; i++) send(0, 2'd1);
        valid0_i = 1'b0;
        drain("midrst");

        // Back-to-back single-word packets with valid_i held high
        exp1_q.push_back(8'hA5); exp1_q.push_back(8'h5A); exp1_q.push_back(8'h55);
`ifdef FRAMER_CHECKSUM_EN
        exp1_q.push_back(8'h55);
`endif
        exp1_q.push_back(8'hA5); exp1_q.push_back(8'h5A); exp1_q.push_back(8'hAA);
`ifdef FRAMER_CHECKSUM_EN
        exp1_q.push_back(8'hAA);
`endif
        fire_cyc1.delete();
        for (int i = 0; i < 4; i++) send(1, 2'd1);
        for (int i = 0; i < 4; i++) send(1, 2'd2);
        valid1_i = 1'b0;
        drain("b2b");
`ifdef FRAMER_CHECKSUM_EN
        n = 4;
`else
        n = 3;
`endif
        check("b2b_count", 32'(fire_cyc1.size()), 32'(2 * n));
        if (fire_cyc1.size() == 2 * n) begin
            check("b2b_gap", 32'(fire_cyc1[n] - fire_cyc1[n-1]), 32'd2);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
